// File: rtl/dmem_lsu_mem.sv
// dmem_lsu_mem: byte-addressable RISC-V load/store data memory behind valid/ready handshakes.
// Define DMEM_BOUNDS_CHECK_EN to fault addresses >= DEPTH instead of aliasing them.
module dmem_lsu_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [1:0]            o_rsp_err_code
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_cnt;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_accept, w_doAccess;
  logic                  w_legal, w_misaligned, w_oob;
  logic [1:0]            w_size, w_code;
  logic [AW-1:0]         w_idx0, w_idx1, w_idx2, w_idx3;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic [31:0]           w_loadData;

  // The WAIT state always lasts at least one cycle; its final cycle is the memory access.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_doAccess = 1'b0;
    case (r_state)
      S_IDLE: if (i_req_valid) begin
        w_accept = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: if (r_cnt == 4'd0) begin
        w_doAccess = 1'b1;
        w_next     = S_RESP;
      end
      S_RESP: if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_req_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oob = |r_addr[ADDR_WIDTH-1:AW];
`else
  logic w_unusedAddr;
  assign w_oob        = 1'b0;
  assign w_unusedAddr = |r_addr[ADDR_WIDTH-1:AW];
`endif

  // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 10 word.
  always_comb begin
    w_size = r_funct3[1:0];
    if (r_we) w_legal = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010);
    else      w_legal = r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_misaligned = ((w_size == 2'b01) && r_addr[0]) ||
                   ((w_size == 2'b10) && (r_addr[1:0] != 2'b00));
    if (!w_legal)          w_code = 2'd2;
    else if (w_misaligned) w_code = 2'd1;
    else if (w_oob)        w_code = 2'd3;
    else                   w_code = 2'd0;
  end

  assign w_idx0 = r_addr[AW-1:0];
  assign w_idx1 = w_idx0 + AW'(1);
  assign w_idx2 = w_idx0 + AW'(2);
  assign w_idx3 = w_idx0 + AW'(3);
  assign w_b0   = r_mem[w_idx0];
  assign w_b1   = r_mem[w_idx1];
  assign w_b2   = r_mem[w_idx2];
  assign w_b3   = r_mem[w_idx3];

  always_comb begin
    w_loadData = 32'h0;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_b0[7]}}, w_b0};
      3'b001:  w_loadData = {{16{w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_loadData = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_loadData = {24'h0, w_b0};
      3'b101:  w_loadData = {16'h0, w_b1, w_b0};
      default: w_loadData = 32'h0;
    endcase
  end

  // Request capture, wait countdown and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we           <= 1'b0;
      r_funct3       <= 3'b000;
      r_addr         <= '0;
      r_wdata        <= 32'h0;
      r_cnt          <= 4'd0;
      o_rsp_valid    <= 1'b0;
      o_rsp_rdata    <= 32'h0;
      o_rsp_err      <= 1'b0;
      o_rsp_err_code <= 2'd0;
    end else begin
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_cnt    <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_doAccess) begin
        o_rsp_valid    <= 1'b1;
        o_rsp_rdata    <= (r_we || w_code != 2'd0) ? 32'h0 : w_loadData;
        o_rsp_err      <= (w_code != 2'd0);
        o_rsp_err_code <= w_code;
      end else if (r_state == S_RESP && i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

  // Word k starts as (DEPTH/4 - k) % 20 in its low byte; only legal stores modify it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= (i % 4 == 0) ? 8'((DEPTH / 4 - i / 4) % 20) : 8'h00;
    end else if (w_doAccess && r_we && w_code == 2'd0) begin
      r_mem[w_idx0] <= r_wdata[7:0];
      if (w_size != 2'b00) r_mem[w_idx1] <= r_wdata[15:8];
      if (w_size == 2'b10) begin
        r_mem[w_idx2] <= r_wdata[23:16];
        r_mem[w_idx3] <= r_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_mem.sv
// tb_dmem_lsu_mem: directed vectors for dmem_lsu_mem; instance A has no wait states,
// instance B has three and is used for latency, back-pressure and mid-access reset.
module tb_dmem_lsu_mem;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        aValid = 1'b0, aReady, aWe = 1'b0, aRspValid, aRspReady = 1'b1, aErr;
  logic [2:0]  aF3 = 3'b0;
  logic [31:0] aAddr = 32'h0, aWd = 32'h0, aRdata;
  logic [1:0]  aCode;

  logic        bValid = 1'b0, bReady, bWe = 1'b0, bRspValid, bRspReady = 1'b0, bErr;
  logic [2:0]  bF3 = 3'b0;
  logic [31:0] bAddr = 32'h0, bWd = 32'h0, bRdata;
  logic [1:0]  bCode;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_lsu_mem #(.ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dutA (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(aValid), .o_req_ready(aReady), .i_req_we(aWe), .i_req_funct3(aF3),
    .i_req_addr(aAddr), .i_req_wdata(aWd),
    .o_rsp_valid(aRspValid), .i_rsp_ready(aRspReady), .o_rsp_rdata(aRdata),
    .o_rsp_err(aErr), .o_rsp_err_code(aCode)
  );

  dmem_lsu_mem #(.ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dutB (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(bValid), .o_req_ready(bReady), .i_req_we(bWe), .i_req_funct3(bF3),
    .i_req_addr(bAddr), .i_req_wdata(bWd),
    .o_rsp_valid(bRspValid), .i_rsp_ready(bRspReady), .o_rsp_rdata(bRdata),
    .o_rsp_err(bErr), .o_rsp_err_code(bCode)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One transaction on instance A (rsp_ready held high); lat counts negedges until rsp_valid.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd,
                               output logic [2:0] errCode, output int lat);
    @(negedge clk);
    aValid = 1'b1; aWe = we; aF3 = f3; aAddr = addr; aWd = wd;
    @(negedge clk);
    aValid = 1'b0;
    lat = 0;
    while (!aRspValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = aRdata;
    errCode = {aErr, aCode};
    @(negedge clk);
  endtask

  task automatic runVector(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] expData, input logic [1:0] expCode);
    logic [31:0] rd;
    logic [2:0]  ec;
    int          lat;
    applyStimulus(we, f3, addr, wd, rd, ec, lat);
    checkOutput({tag, "/data"}, rd, expData);
    checkOutput({tag, "/err"}, {29'h0, ec}, {29'h0, expCode != 2'd0, expCode});
    checkOutput({tag, "/lat"}, lat, 32'd1);
  endtask

  // One transaction on instance B holding rsp_ready low for holdCycles after rsp_valid.
  task automatic applySlow(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int holdCycles,
                           output logic [31:0] rd, output logic [2:0] errCode,
                           output int lat, output int unstable);
    @(negedge clk);
    bValid = 1'b1; bWe = we; bF3 = f3; bAddr = addr; bWd = wd; bRspReady = 1'b0;
    @(negedge clk);
    bValid = 1'b0;
    lat = 0;
    unstable = 0;
    while (!bRspValid && lat < 40) begin
      if (bReady) unstable++;
      @(negedge clk);
      lat++;
    end
    rd = bRdata;
    errCode = {bErr, bCode};
    repeat (holdCycles) begin
      @(negedge clk);
      if (bRdata !== rd || {bErr, bCode} !== errCode || !bRspValid || bReady) unstable++;
    end
    bRspReady = 1'b1;
    @(negedge clk);
    bRspReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  ec;
    int          lat, unstable;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReqReady", {31'h0, aReady}, 32'h1);
    checkOutput("rstRspValid", {31'h0, aRspValid}, 32'h0);
    checkOutput("rstRdata", aRdata, 32'h0);
    checkOutput("rstErr", {29'h0, aErr, aCode}, 32'h0);

    $display("[TB] reset-value loads");
    runVector("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0010, 2'd0);
    runVector("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h0000_000F, 2'd0);

    $display("[TB] word store then sub-word loads");
    runVector("sw8",   1'b1, 3'b010, 32'h8, 32'h8081_FF7F, 32'h0, 2'd0);
    runVector("lb8",   1'b0, 3'b000, 32'h8, 32'h0, 32'h0000_007F, 2'd0);
    runVector("lb9",   1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FFFF, 2'd0);
    runVector("lbu9",  1'b0, 3'b100, 32'h9, 32'h0, 32'h0000_00FF, 2'd0);
    runVector("lhA",   1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFF_8081, 2'd0);
    runVector("lhuA",  1'b0, 3'b101, 32'hA, 32'h0, 32'h0000_8081, 2'd0);
    runVector("lw8",   1'b0, 3'b010, 32'h8, 32'h0, 32'h8081_FF7F, 2'd0);

    $display("[TB] byte and halfword stores");
    runVector("sb11",  1'b1, 3'b000, 32'h11, 32'h1234_56AB, 32'h0, 2'd0);
    runVector("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_AB0C, 2'd0);
    runVector("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_AB0C, 2'd0);
    runVector("sh16",  1'b1, 3'b001, 32'h16, 32'hCAFE_1234, 32'h0, 2'd0);
    runVector("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h1234_000B, 2'd0);

    $display("[TB] faults");
    runVector("lw6",    1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 2'd1);
    runVector("lw2",    1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 2'd1);
    runVector("lh5",    1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 2'd1);
    runVector("sh3",    1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 32'h0, 2'd1);
    runVector("lw0chk", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0010, 2'd0);
    runVector("ld011",  1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 2'd2);
    runVector("ld011m", 1'b0, 3'b011, 32'h1, 32'h0, 32'h0, 2'd2);
    runVector("st100",  1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF, 32'h0, 2'd2);
    runVector("lw4chk", 1'b0, 3'b010, 32'h4, 32'h0, 32'h0000_000F, 2'd0);
    runVector("lw401",  1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 2'd1);
`ifdef DMEM_BOUNDS_CHECK_EN
    runVector("lw400",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 2'd3);
`else
    runVector("lw400",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0000_0010, 2'd0);
`endif

    $display("[TB] wait states and back-pressure");
    applySlow(1'b0, 3'b010, 32'h4, 32'h0, 5, rd, ec, lat, unstable);
    checkOutput("slowLat", lat, 32'd4);
    checkOutput("slowData", rd, 32'h0000_000F);
    checkOutput("slowErr", {29'h0, ec}, 32'h0);
    checkOutput("slowStable", unstable, 32'd0);
    checkOutput("slowDone", {30'h0, bRspValid, bReady}, 32'h1);

    $display("[TB] reset during a pending store");
    @(negedge clk);
    bValid = 1'b1; bWe = 1'b1; bF3 = 3'b010; bAddr = 32'h20; bWd = 32'hDEAD_BEEF;
    @(negedge clk);
    bValid = 1'b0;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rstMidIdle", {30'h0, bRspValid, bReady}, 32'h1);
    applySlow(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, ec, lat, unstable);
    checkOutput("rstMidData", rd, 32'h0000_0008);
    checkOutput("rstMidErr", {29'h0, ec}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
